// File: rtl/enc_823_ser_pkg.sv
// Shared constants and types for the 8-bit multi-hot to 3-bit index serializer.
// Holds the vector/index widths and the two-state FSM encoding.
package enc_823_ser_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // One output beat as seen on the Out_* bus.
  typedef struct packed {
    logic [IDX_W-1:0] es;
    logic             last;
    logic             zero;
  } beat_t;

  // Drops the lowest set bit; used to retire a beat from the pending vector.
  function automatic logic [VEC_W-1:0] clr_lowest(input logic [VEC_W-1:0] v);
    return v & (v - VEC_W'(1));
  endfunction

endpackage

// File: rtl/penc_8to3_lsb.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit vector.
// any_o flags a non-zero input; idx_o is 0 when the input is all-zero.
module penc_8to3_lsb
  import enc_823_ser_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scanning from MSB down lets the lowest set bit win the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/enc_823_ser.sv
// Serializes an accepted multi-hot vector into one index beat per set bit, LSB first.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module enc_823_ser
  import enc_823_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             In_vld,
  output logic             In_rdy,
  input  logic [VEC_W-1:0] In_es,
  output logic             Out_vld,
  input  logic             Out_rdy,
  output logic [IDX_W-1:0] Out_es,
  output logic             Out_last,
  output logic             Out_zero
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] low_idx;
  logic             pend_any;
  logic             pend_single;
  logic             emit;
  logic             in_hs;
  logic             out_hs;

  penc_8to3_lsb u_penc (
    .vec_i (pending_q),
    .idx_o (low_idx),
    .any_o (pend_any)
  );

  assign emit        = (state_q == ST_EMIT);
  assign pend_single = pend_any && ((pending_q & (pending_q - VEC_W'(1))) == '0);

  // Outputs decode only registered state, so they hold while the sink stalls.
  assign Out_vld  = emit;
  assign Out_zero = emit & zero_q;
  assign Out_last = emit & (zero_q | pend_single);
  assign Out_es   = (emit && !zero_q) ? low_idx : '0;

  // The final beat leaving this cycle frees the slot for a back-to-back vector.
  assign In_rdy = !emit || (Out_last && Out_rdy);

  assign in_hs  = In_vld & In_rdy;
  assign out_hs = Out_vld & Out_rdy;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    if (out_hs) begin
      if (Out_last) begin
        state_d   = ST_IDLE;
        pending_d = '0;
        zero_d    = 1'b0;
      end else begin
        pending_d = clr_lowest(pending_q);
      end
    end
    if (in_hs) begin
      state_d   = ST_EMIT;
      pending_d = In_es;
      zero_d    = (In_es == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_enc_823_ser.sv
// Bench for enc_823_ser: table of vectors with hand-derived beats, directed corner
// sequences, and a scoreboard that predicts every beat from each accepted vector.
module tb_enc_823_ser;

  logic       clk = 1'b0;
  logic       rst;
  logic       In_vld;
  logic       In_rdy;
  logic [7:0] In_es;
  logic       Out_vld;
  logic       Out_rdy = 1'b1;
  logic [2:0] Out_es;
  logic       Out_last;
  logic       Out_zero;

  enc_823_ser dut (
    .clk      (clk),
    .rst      (rst),
    .In_vld   (In_vld),
    .In_rdy   (In_rdy),
    .In_es    (In_es),
    .Out_vld  (Out_vld),
    .Out_rdy  (Out_rdy),
    .Out_es   (Out_es),
    .Out_last (Out_last),
    .Out_zero (Out_zero)
  );

  // ---------------- clock / reset / ready driver ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy_mode = 0;  // 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #3;
    case (rdy_mode)
      0:       Out_rdy = 1'b1;
      1:       Out_rdy = 1'($urandom_range(0, 1));
      default: Out_rdy = 1'b0;
    endcase
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  logic [4:0] exp_q[$];
  int         cap_es[$];
  logic       cap_last[$];
  logic       cap_zero[$];
  int         cap_cyc[$];
  int         acc_cyc;

  task automatic push_exp(input logic [7:0] v);
    logic [7:0] rest;
    if (v == 8'h00) begin
      exp_q.push_back({3'd0, 1'b1, 1'b1});
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          rest = v >> (i + 1);
          exp_q.push_back({3'(i), (rest == 8'h00), 1'b0});
        end
      end
    end
  endtask

  task automatic clear_cap();
    cap_es.delete();
    cap_last.delete();
    cap_zero.delete();
    cap_cyc.delete();
  endtask

  // Monitor: beats are compared the half-cycle before the edge that transfers them.
  logic       stall_seen = 1'b0;
  logic [4:0] stall_val;
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_vld", 32'(Out_vld), 32'd1);
        chk("hold_beat", 32'({Out_es, Out_last, Out_zero}), 32'(stall_val));
      end
      stall_seen = Out_vld && !Out_rdy;
      stall_val  = {Out_es, Out_last, Out_zero};
      if (Out_vld && Out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'(Out_vld), 32'd0);
        end else begin
          chk("beat", 32'({Out_es, Out_last, Out_zero}), 32'(exp_q.pop_front()));
        end
        cap_es.push_back(int'(Out_es));
        cap_last.push_back(Out_last);
        cap_zero.push_back(Out_zero);
        cap_cyc.push_back(cyc);
      end
      if (In_vld && In_rdy) begin
        push_exp(In_es);
        acc_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Leaves In_vld high after acceptance so a following send can be back-to-back.
  task automatic send(input logic [7:0] v);
    bit ok = 1'b0;
    int t  = 0;
    In_vld = 1'b1;
    In_es  = v;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (In_rdy) ok = 1'b1;
      t++;
    end
    if (!ok) chk("send_timeout", 32'(In_rdy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic in_idle();
    In_vld = 1'b0;
    In_es  = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    bit done = 1'b0;
    int t    = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !Out_vld) done = 1'b1;
      t++;
    end
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  es;
    int          n;
    logic [23:0] idx;  // beat k index in idx[3k +: 3]
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [23:0] idx_v;
    int          k;
    int          t;

    tbl[0] = '{8'hA4, 3, {15'd0, 3'd7, 3'd5, 3'd2}};
    tbl[1] = '{8'h00, 1, 24'd0};
    tbl[2] = '{8'h81, 2, {18'd0, 3'd7, 3'd0}};
    tbl[3] = '{8'h10, 1, {21'd0, 3'd4}};
    tbl[4] = '{8'h80, 1, {21'd0, 3'd7}};
    tbl[5] = '{8'h01, 1, 24'd0};
    tbl[6] = '{8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[7] = '{8'h3C, 4, {12'd0, 3'd5, 3'd4, 3'd3, 3'd2}};

    rst    = 1'b1;
    In_vld = 1'b0;
    In_es  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", 32'(Out_vld), 32'd0);
    chk("rst_out_es", 32'(Out_es), 32'd0);
    chk("rst_out_last", 32'(Out_last), 32'd0);
    chk("rst_out_zero", 32'(Out_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_rdy", 32'(In_rdy), 32'd1);
    chk("post_rst_out_vld", 32'(Out_vld), 32'd0);

    // Table: full-rate sink, one vector at a time.
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      clear_cap();
      send(tbl[i].es);
      in_idle();
      drain();
      idx_v = tbl[i].idx;
      chk("tbl_nbeats", 32'(cap_es.size()), 32'(tbl[i].n));
      for (k = 0; k < cap_es.size() && k < tbl[i].n; k++) begin
        chk("tbl_es", 32'(cap_es[k]), 32'(idx_v[3*k +: 3]));
        chk("tbl_last", 32'(cap_last[k]), 32'(k == tbl[i].n - 1));
        chk("tbl_zero", 32'(cap_zero[k]), 32'(tbl[i].es == 8'h00));
        chk("tbl_cycle", 32'(cap_cyc[k]), 32'(acc_cyc + 1 + k));
      end
      chk("tbl_in_rdy_after", 32'(In_rdy), 32'd1);
    end

    // Sink stalls three cycles on the first beat of 8'h81.
    rdy_mode = 2;
    clear_cap();
    send(8'h81);
    in_idle();
    repeat (3) begin
      @(negedge clk);
      chk("stall_vld", 32'(Out_vld), 32'd1);
      chk("stall_es", 32'(Out_es), 32'd0);
    end
    rdy_mode = 0;
    drain();
    chk("stall_nbeats", 32'(cap_es.size()), 32'd2);
    if (cap_es.size() == 2) begin
      chk("stall_es0", 32'(cap_es[0]), 32'd0);
      chk("stall_es1", 32'(cap_es[1]), 32'd7);
      chk("stall_last0", 32'(cap_last[0]), 32'd0);
      chk("stall_last1", 32'(cap_last[1]), 32'd1);
    end

    // Back-to-back: 8'h10 then 8'h03 with valid held, no bubble between.
    clear_cap();
    send(8'h10);
    send(8'h03);
    in_idle();
    drain();
    chk("b2b_nbeats", 32'(cap_es.size()), 32'd3);
    if (cap_es.size() == 3) begin
      chk("b2b_es0", 32'(cap_es[0]), 32'd4);
      chk("b2b_es1", 32'(cap_es[1]), 32'd0);
      chk("b2b_es2", 32'(cap_es[2]), 32'd1);
      chk("b2b_last0", 32'(cap_last[0]), 32'd1);
      chk("b2b_last1", 32'(cap_last[1]), 32'd0);
      chk("b2b_last2", 32'(cap_last[2]), 32'd1);
      chk("b2b_cyc1", 32'(cap_cyc[1]), 32'(cap_cyc[0] + 1));
      chk("b2b_cyc2", 32'(cap_cyc[2]), 32'(cap_cyc[0] + 2));
    end

    // Reset after the third beat of 8'hFF.
    clear_cap();
    send(8'hFF);
    in_idle();
    t = 0;
    while (cap_es.size() < 3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("rst_mid_reached", 32'(cap_es.size()), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_vld", 32'(Out_vld), 32'd0);
    chk("rst_mid_out_es", 32'(Out_es), 32'd0);
    chk("rst_mid_out_last", 32'(Out_last), 32'd0);
    chk("rst_mid_pending", 32'(dut.pending_q), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_quiet", 32'(Out_vld), 32'd0);
    end
    @(posedge clk);
    #1;
    clear_cap();
    send(8'h40);
    in_idle();
    drain();
    chk("rst_mid_next_nbeats", 32'(cap_es.size()), 32'd1);
    if (cap_es.size() == 1) begin
      chk("rst_mid_next_es", 32'(cap_es[0]), 32'd6);
      chk("rst_mid_next_last", 32'(cap_last[0]), 32'd1);
    end

    // Sweep every vector with a random-ready sink; the scoreboard checks each beat.
    rdy_mode = 1;
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      if ($urandom_range(0, 3) == 0) begin
        in_idle();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    in_idle();
    rdy_mode = 0;
    drain();
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/enc_823_ser.md
ENC_823_SER -- requirements
Module: enc_823_ser

Interface
REQ-001 SHALL have no parameters; widths fixed at 8-bit input vector, 3-bit index.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 In_vld  input  1  input vector valid.
REQ-005 In_rdy  output  1  block can accept a vector this cycle.
REQ-006 In_es  input  8  multi-hot request vector.
REQ-007 Out_vld  output  1  Out_es/Out_last/Out_zero valid.
REQ-008 Out_rdy  input  1  downstream accepts current beat.
REQ-009 Out_es  output  3  index of a set bit of the accepted vector.
REQ-010 Out_last  output  1  current beat is final beat for this vector.
REQ-011 Out_zero  output  1  accepted vector was all-zero; Out_es=0 on that beat.

Function
REQ-012 SHALL have two states, IDLE and EMIT; pending 8-bit register holds bits not yet emitted.
REQ-013 Input handshake = In_vld & In_rdy in same cycle; output handshake = Out_vld & Out_rdy in same cycle.
REQ-014 IDLE: In_rdy=1, Out_vld=0; on input handshake load pending<=In_es, zero flag<=(In_es==0), go EMIT.
REQ-015 EMIT: Out_vld=1; Out_es = index of lowest set bit of pending (LSB-first order).
REQ-016 EMIT: Out_last=1 when pending has exactly one set bit or zero flag is set.
REQ-017 EMIT with zero flag: exactly one beat, Out_es=0, Out_zero=1, Out_last=1; otherwise Out_zero=0.
REQ-018 On output handshake with Out_last=0: clear lowest set bit of pending, stay EMIT.
REQ-019 On output handshake with Out_last=1: return IDLE unless a new input is accepted the same cycle.
REQ-020 In_rdy=1 in EMIT only when Out_last & Out_rdy (back-to-back accept); new vector then loads and state stays EMIT.
REQ-021 Latency: first beat valid the cycle after input handshake; one beat per cycle when Out_rdy held high; N set bits -> N beats.
REQ-022 Out_es, Out_last, Out_zero SHALL hold stable while Out_vld=1 and Out_rdy=0.
REQ-023 In_es ignored in any cycle without input handshake.
REQ-024 Out_rdy ignored while Out_vld=0.

Reset
REQ-025 rst=1 asynchronously forces IDLE, pending=0, zero flag=0.
REQ-026 During and after reset: In_rdy=1 (after release), Out_vld=0, Out_es=0, Out_last=0, Out_zero=0.
REQ-027 Reset mid-EMIT discards remaining beats; no beat emitted after release until a new input handshake.

Structure
REQ-028 Shared package SHALL hold state encoding constants (IDLE, EMIT) and width constants (8 vector, 3 index).
REQ-029 Lowest-set-bit lookup SHALL be a combinational sub-module penc_8to3_lsb (8-bit in, 3-bit index, any-bit flag).
REQ-030 Single-bit test SHALL use pending & (pending-1) == 0 within enc_823_ser.

Verification
REQ-031 In_es=8'b1010_0100, Out_rdy=1 -> beats Out_es=2,5,7 on consecutive cycles, Out_last only on 7, then In_rdy=1.
REQ-032 In_es=8'h00 -> single beat Out_es=0, Out_zero=1, Out_last=1.
REQ-033 In_es=8'h81, Out_rdy low 3 cycles at first beat -> Out_es=0 held 3 cycles, then 0, 7.
REQ-034 In_es=8'h10 then In_es=8'h03 held valid -> beats 4(last), 0, 1(last) with no bubble between vectors.
REQ-035 In_es=8'hFF, assert rst after third beat -> Out_vld=0 immediately, pending=0; next In_es=8'h40 -> single beat 6.
REQ-036 Exhaustive sweep of all 256 In_es with random Out_rdy -> emitted index set equals set-bit set, ascending, one Out_last per vector.
